// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder
//
// Pulls raw PS/2 set-2 scan bytes out of an upstream keyboard FIFO and turns
// them into key events. Each event carries the final scan code, whether an E0
// prefix was present, and whether it is a press or a release. A typematic
// repeat flag marks presses of keys that are already held. The block also
// tracks the shift/ctrl/alt held state and the caps-lock toggle.
//
// Ports
//   clk            : single clock, rising edge
//   rst            : asynchronous active-high reset
//   kbd_data[7:0]  : scan byte at the head of the upstream FIFO
//   kbd_ready      : upstream FIFO non-empty
//   kbd_nextdata_n : active-low one-cycle pop strobe to the upstream FIFO
//   evt_valid      : a key event is held on the evt_* outputs
//   evt_ready      : consumer accepts the event
//   evt_code[7:0]  : final scan code of the event
//   evt_ext        : E0 prefix was present
//   evt_break      : 1 = release, 0 = press
//   evt_repeat     : press of a key already held
//   shift_held, ctrl_held, alt_held, caps_lock : modifier state
module ps2_scancode_decoder (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] kbd_data,
   input  logic       kbd_ready,
   output logic       kbd_nextdata_n,
   output logic       evt_valid,
   input  logic       evt_ready,
   output logic [7:0] evt_code,
   output logic       evt_ext,
   output logic       evt_break,
   output logic       evt_repeat,
   output logic       shift_held,
   output logic       ctrl_held,
   output logic       alt_held,
   output logic       caps_lock
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      POP  = 2'd1,
      WAIT = 2'd2
   } state_t;

   // Status/ack bytes that carry no key information when no prefix is pending.
   localparam logic [47:0] DISCARD_CODES = {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};

   // Bitmap indices {ext, code} of the modifier keys.
   localparam logic [8:0] IDX_LSHIFT = 9'h012;
   localparam logic [8:0] IDX_RSHIFT = 9'h059;
   localparam logic [8:0] IDX_LCTRL  = 9'h014;
   localparam logic [8:0] IDX_RCTRL  = 9'h114;
   localparam logic [8:0] IDX_LALT   = 9'h011;
   localparam logic [8:0] IDX_RALT   = 9'h111;
   localparam logic [8:0] IDX_CAPS   = 9'h058;

   state_t       state_reg, state_next;
   logic         nextdata_n_reg, nextdata_n_next;

   logic [2:0]   skip_cnt_reg;
   logic         ext_pend_reg;
   logic         brk_pend_reg;
   logic [511:0] bitmap_reg;
   logic         caps_reg;

   logic         evt_valid_reg;
   logic [7:0]   evt_code_reg;
   logic         evt_ext_reg;
   logic         evt_break_reg;
   logic         evt_repeat_reg;

   // ------------------------------------------------------------------
   // Pop FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= IDLE;
         nextdata_n_reg <= 1'b1;
      end else begin
         state_reg      <= state_next;
         nextdata_n_reg <= nextdata_n_next;
      end
   end

   // Pop FSM: next state. A new byte is only fetched while no event is held,
   // which is what pushes backpressure into the upstream FIFO.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (kbd_ready && !evt_valid_reg) state_next = POP;
         POP:     state_next = WAIT;
         WAIT:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Pop FSM: outputs. The strobe is registered, so it is computed from the
   // state being entered and is low for exactly the POP cycle.
   always_comb begin
      nextdata_n_next = 1'b1;
      if (state_next == POP) nextdata_n_next = 1'b0;
   end

   // ------------------------------------------------------------------
   // Byte classification
   // ------------------------------------------------------------------
   logic [5:0] discard_hit;

   generate
      for (genvar gi = 0; gi < 6; gi++) begin : g_discard
         assign discard_hit[gi] = (kbd_data == DISCARD_CODES[gi*8 +: 8]);
      end
   endgenerate

   logic       sample;
   logic       skipping;
   logic       is_e1, is_e0, is_f0, is_discard;
   logic [8:0] key_idx;
   logic       key_held;

   assign sample     = (state_reg == POP);
   assign skipping   = (skip_cnt_reg != 3'd0);
   assign is_e1      = (kbd_data == 8'hE1);
   assign is_e0      = (kbd_data == 8'hE0);
   assign is_f0      = (kbd_data == 8'hF0);
   assign is_discard = (|discard_hit) && !ext_pend_reg && !brk_pend_reg;
   assign key_idx    = {ext_pend_reg, kbd_data};
   assign key_held   = bitmap_reg[key_idx];

   // ------------------------------------------------------------------
   // Decode datapath, event register and key bitmap
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         skip_cnt_reg   <= 3'd0;
         ext_pend_reg   <= 1'b0;
         brk_pend_reg   <= 1'b0;
         bitmap_reg     <= '0;
         caps_reg       <= 1'b0;
         evt_valid_reg  <= 1'b0;
         evt_code_reg   <= 8'h00;
         evt_ext_reg    <= 1'b0;
         evt_break_reg  <= 1'b0;
         evt_repeat_reg <= 1'b0;
      end else begin
         if (evt_valid_reg && evt_ready) evt_valid_reg <= 1'b0;

         // evt_valid is always 0 while sampling (POP is only entered with no
         // event held), so a completion never collides with a held event.
         if (sample) begin
            if (skipping) begin
               skip_cnt_reg <= skip_cnt_reg - 3'd1;
            end else if (is_e1) begin
               // Pause key: E1 followed by seven bytes that carry no key.
               skip_cnt_reg <= 3'd7;
            end else if (is_e0) begin
               ext_pend_reg <= 1'b1;
            end else if (is_f0) begin
               brk_pend_reg <= 1'b1;
            end else if (!is_discard) begin
               evt_valid_reg       <= 1'b1;
               evt_code_reg        <= kbd_data;
               evt_ext_reg         <= ext_pend_reg;
               evt_break_reg       <= brk_pend_reg;
               evt_repeat_reg      <= !brk_pend_reg && key_held;
               bitmap_reg[key_idx] <= !brk_pend_reg;
               ext_pend_reg        <= 1'b0;
               brk_pend_reg        <= 1'b0;
               if (!brk_pend_reg && !key_held && (key_idx == IDX_CAPS))
                  caps_reg <= !caps_reg;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign kbd_nextdata_n = nextdata_n_reg;
   assign evt_valid      = evt_valid_reg;
   assign evt_code       = evt_code_reg;
   assign evt_ext        = evt_ext_reg;
   assign evt_break      = evt_break_reg;
   assign evt_repeat     = evt_repeat_reg;

   // Derived straight from the bitmap so they change on the completion edge.
   assign shift_held = bitmap_reg[IDX_LSHIFT] | bitmap_reg[IDX_RSHIFT];
   assign ctrl_held  = bitmap_reg[IDX_LCTRL]  | bitmap_reg[IDX_RCTRL];
   assign alt_held   = bitmap_reg[IDX_LALT]   | bitmap_reg[IDX_RALT];
   assign caps_lock  = caps_reg;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Testbench for ps2_scancode_decoder: a queue-based model of the upstream
// keyboard FIFO feeds scan bytes; expected events are pushed to a scoreboard
// when the bytes are queued and popped when the DUT hands an event over.
module tb_ps2_scancode_decoder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] kbd_data = 8'h00;
   logic       kbd_ready = 1'b0;
   logic       kbd_nextdata_n;
   logic       evt_valid;
   logic       evt_ready = 1'b1;
   logic [7:0] evt_code;
   logic       evt_ext, evt_break, evt_repeat;
   logic       shift_held, ctrl_held, alt_held, caps_lock;

   always #5 clk = ~clk;

   ps2_scancode_decoder dut (
      .clk            (clk),
      .rst            (rst),
      .kbd_data       (kbd_data),
      .kbd_ready      (kbd_ready),
      .kbd_nextdata_n (kbd_nextdata_n),
      .evt_valid      (evt_valid),
      .evt_ready      (evt_ready),
      .evt_code       (evt_code),
      .evt_ext        (evt_ext),
      .evt_break      (evt_break),
      .evt_repeat     (evt_repeat),
      .shift_held     (shift_held),
      .ctrl_held      (ctrl_held),
      .alt_held       (alt_held),
      .caps_lock      (caps_lock)
   );

   // Expected event: code, ext, break, repeat, {shift, ctrl, alt, caps}
   typedef struct packed {
      logic [7:0] code;
      logic       ext;
      logic       brk;
      logic       rep;
      logic [3:0] mods;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] push_q[$];
   logic [7:0] fifo_q[$];

   int   checks = 0;
   int   errors = 0;
   int   pop_cnt = 0;
   logic prev_pop_low = 1'b0;

   // Upstream FIFO model: pops on the edge that sees the strobe low, then
   // absorbs newly queued bytes; head/ready are updated after the edge.
   always @(posedge clk) begin
      if (!kbd_nextdata_n && fifo_q.size() != 0) fifo_q.delete(0);
      while (push_q.size() != 0) fifo_q.push_back(push_q.pop_front());
      kbd_ready <= (fifo_q.size() != 0);
      kbd_data  <= (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
   end

   // Monitor: pop strobe legality and scoreboard comparison on handshakes.
   always @(negedge clk) begin
      if (!rst) begin
         if (!kbd_nextdata_n) begin
            pop_cnt++;
            checks++;
            assert (kbd_ready === 1'b1 && prev_pop_low === 1'b0) else begin
               errors++;
               $error("FAIL pop_strobe: observed ready=%0b prev_low=%0b, expected ready=1 prev_low=0",
                      kbd_ready, prev_pop_low);
            end
         end
         prev_pop_low = !kbd_nextdata_n;
         if (evt_valid && evt_ready) begin
            exp_t obs, e;
            obs = {evt_code, evt_ext, evt_break, evt_repeat,
                   shift_held, ctrl_held, alt_held, caps_lock};
            checks++;
            assert (exp_q.size() != 0) else begin
               errors++;
               $error("FAIL unexpected_event: observed %h, expected no event", obs);
            end
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               checks++;
               assert (obs === e) else begin
                  errors++;
                  $error("FAIL event: observed code=%h ext=%0b brk=%0b rep=%0b mods=%b, expected code=%h ext=%0b brk=%0b rep=%0b mods=%b",
                         obs.code, obs.ext, obs.brk, obs.rep, obs.mods,
                         e.code, e.ext, e.brk, e.rep, e.mods);
               end
            end
         end
      end else begin
         prev_pop_low = 1'b0;
      end
   end

   task automatic push(input logic [7:0] b);
      push_q.push_back(b);
   endtask

   task automatic expect_evt(input logic [7:0] code, input logic ext, input logic brk,
                             input logic rep, input logic [3:0] mods);
      exp_t e;
      e.code = code; e.ext = ext; e.brk = brk; e.rep = rep; e.mods = mods;
      exp_q.push_back(e);
   endtask

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   // Let the queued bytes and expected events drain, bounded in cycles.
   task automatic drain(input string tag);
      int n = 0;
      while ((exp_q.size() != 0 || push_q.size() != 0 || fifo_q.size() != 0 || evt_valid)
             && n < 500) begin
         @(posedge clk);
         n++;
      end
      repeat (3) @(posedge clk);
      #1;
      check_val({tag, "_drain"}, exp_q.size() + fifo_q.size(), 0);
   endtask

   initial begin
      int p0;
      int n;

      // Reset state
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_val("reset_outputs",
                {evt_valid, evt_code, evt_ext, evt_break, evt_repeat,
                 shift_held, ctrl_held, alt_held, caps_lock, kbd_nextdata_n},
                32'h00001);
      rst = 1'b0;
      $display("step: reset released");

      // Press and release of 1C
      p0 = pop_cnt;
      push(8'h1C);              expect_evt(8'h1C, 1'b0, 1'b0, 1'b0, 4'b0000);
      push(8'hF0); push(8'h1C); expect_evt(8'h1C, 1'b0, 1'b1, 1'b0, 4'b0000);
      drain("press_release");
      check_val("press_release_pops", pop_cnt - p0, 3);
      $display("step: 1C press/release, pops=%0d", pop_cnt - p0);

      // Extended release E0 F0 75; bit was never set but the event still appears
      p0 = pop_cnt;
      push(8'hE0); push(8'hF0); push(8'h75);
      expect_evt(8'h75, 1'b1, 1'b1, 1'b0, 4'b0000);
      drain("ext_break");
      check_val("ext_break_pops", pop_cnt - p0, 3);
      $display("step: E0 F0 75, pops=%0d", pop_cnt - p0);

      // Typematic shift: 12,12,12,F0,12
      push(8'h12); expect_evt(8'h12, 1'b0, 1'b0, 1'b0, 4'b1000);
      push(8'h12); expect_evt(8'h12, 1'b0, 1'b0, 1'b1, 4'b1000);
      push(8'h12); expect_evt(8'h12, 1'b0, 1'b0, 1'b1, 4'b1000);
      push(8'hF0); push(8'h12); expect_evt(8'h12, 1'b0, 1'b1, 1'b0, 4'b0000);
      drain("typematic");
      check_val("typematic_shift_after", shift_held, 0);
      $display("step: typematic shift done");

      // Backpressure: consumer stalls with four bytes queued
      evt_ready = 1'b0;
      p0 = pop_cnt;
      push(8'h14); expect_evt(8'h14, 1'b0, 1'b0, 1'b0, 4'b0100);
      push(8'h11); expect_evt(8'h11, 1'b0, 1'b0, 1'b0, 4'b0110);
      push(8'h5A); expect_evt(8'h5A, 1'b0, 1'b0, 1'b0, 4'b0110);
      push(8'h29); expect_evt(8'h29, 1'b0, 1'b0, 1'b0, 4'b0110);
      n = 0;
      while (!evt_valid && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_val("bp_first_valid", evt_valid, 1);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         check_val("bp_stable", {evt_valid, evt_code}, {1'b1, 8'h14});
      end
      check_val("bp_single_pop", pop_cnt - p0, 1);
      @(posedge clk);
      #1;
      evt_ready = 1'b1;
      push(8'hF0); push(8'h14); expect_evt(8'h14, 1'b0, 1'b1, 1'b0, 4'b0010);
      push(8'hF0); push(8'h11); expect_evt(8'h11, 1'b0, 1'b1, 1'b0, 4'b0000);
      drain("backpressure");
      check_val("bp_total_pops", pop_cnt - p0, 8);
      $display("step: backpressure, pops=%0d", pop_cnt - p0);

      // Pause sequence swallowed, then caps lock press
      p0 = pop_cnt;
      push(8'hE1); push(8'h14); push(8'h77); push(8'hE1);
      push(8'hF0); push(8'h14); push(8'hF0); push(8'h77);
      push(8'h58); expect_evt(8'h58, 1'b0, 1'b0, 1'b0, 4'b0001);
      drain("pause");
      check_val("pause_pops", pop_cnt - p0, 9);
      check_val("pause_caps", caps_lock, 1);
      $display("step: pause + caps, pops=%0d", pop_cnt - p0);

      // Reset with an E0 prefix pending and 1C held down
      push(8'h1C); expect_evt(8'h1C, 1'b0, 1'b0, 1'b0, 4'b0001);
      drain("pre_reset");
      p0 = pop_cnt;
      push(8'hE0);
      n = 0;
      while (pop_cnt == p0 && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      repeat (3) @(posedge clk);
      #1;
      check_val("prefix_no_event", {evt_valid, pop_cnt - p0}, {1'b0, 32'd1});
      rst = 1'b1;
      #1;
      check_val("reset_async",
                {evt_valid, evt_code, evt_ext, evt_break, evt_repeat,
                 shift_held, ctrl_held, alt_held, caps_lock, kbd_nextdata_n},
                32'h00001);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      push(8'h1C); expect_evt(8'h1C, 1'b0, 1'b0, 1'b0, 4'b0000);
      drain("post_reset");
      $display("step: reset mid-sequence done");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
